// File: rtl/fft_frame_ctrl.sv
// CPU-facing frame controller for a combinational-interface FFT core: loads N samples,
// launches the core, captures its result and lets the CPU drain it. Optional macro: FFT_FRAME_AUTO_START_EN.
module fft_frame_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NO_STAGES    = 4,
  parameter int CORE_LATENCY = 10
) (
  input  logic                                       clkk,
  input  logic                                       reset,
  input  logic                                       cpu_if_read,
  input  logic                                       cpu_if_write,
  input  logic [ADDR_WIDTH-1:0]                      cpu_if_address,
  input  logic [DATA_WIDTH-1:0]                      cpu_if_write_data,
  output logic [DATA_WIDTH-1:0]                      cpu_if_read_data,
  output logic                                       cpu_if_access_complete,
  output logic [(2**NO_STAGES)*(DATA_WIDTH/2)-1:0]   core_x_N,
  input  logic [(2**NO_STAGES)*(DATA_WIDTH/2)-1:0]   core_y_N,
  output logic                                       core_start,
  output logic                                       error,
  output logic                                       irq
);
  localparam int SW = DATA_WIDTH / 2;
  localparam int N  = 2 ** NO_STAGES;
  localparam int CW = NO_STAGES + 1;
  localparam int LW = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] x_mem [N];
  logic [SW-1:0] y_mem [N];

  // CPU port: read/write are one-cycle strobes with no back-pressure. Every strobe
  // is acknowledged by access_complete on the following cycle, read_data valid with it.
  logic [1:0] reg_sel;
  logic       conflict, wr_ok, rd_ok;
  logic       in_wr, in_accept, out_rd, out_accept, last_out;
  logic       launch, capture, err_set, err_clr;
  logic [31:0]           status_word;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  unused_bits;

  assign reg_sel  = cpu_if_address[3:2];
  assign conflict = cpu_if_read & cpu_if_write;
  assign wr_ok    = cpu_if_write & ~cpu_if_read;
  assign rd_ok    = cpu_if_read & ~cpu_if_write;
  assign irq      = (state == ST_DRAIN);

  assign unused_bits = ^{cpu_if_address[ADDR_WIDTH-1:4], cpu_if_address[1:0],
                         cpu_if_write_data[DATA_WIDTH-1:SW], cpu_if_write_data[0]};

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign core_x_N[g*SW +: SW] = x_mem[g];
  end

  always_comb begin
    in_wr      = wr_ok && (reg_sel == 2'd2);
    in_accept  = in_wr && (state == ST_LOAD) && (in_cnt != CW'(N));
    out_rd     = rd_ok && (reg_sel == 2'd3);
    out_accept = out_rd && (state == ST_DRAIN);
    last_out   = out_accept && (out_cnt == CW'(N - 1));
    capture    = (state == ST_RUN) && (lat_cnt == LW'(CORE_LATENCY));
`ifdef FFT_FRAME_AUTO_START_EN
    launch     = in_accept && (in_cnt == CW'(N - 1));
`else
    launch     = wr_ok && (reg_sel == 2'd0) && cpu_if_write_data[0] &&
                 (state == ST_LOAD) && (in_cnt == CW'(N));
`endif
    err_set    = conflict | (in_wr & ~in_accept) | (out_rd & ~out_accept);
    err_clr    = wr_ok && (reg_sel == 2'd0) && cpu_if_write_data[1];
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (launch)   state_nx = ST_RUN;
      ST_RUN:   if (capture)  state_nx = ST_DRAIN;
      ST_DRAIN: if (last_out) state_nx = ST_LOAD;
      default:                state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    status_word = {error, 5'd0, state, 12'(out_cnt), 12'(in_cnt)};
    rd_value    = '0;
    if (rd_ok) begin
      case (reg_sel)
        2'd1:    rd_value = DATA_WIDTH'(status_word);
        2'd3:    if (out_accept) rd_value = DATA_WIDTH'(y_mem[out_cnt[NO_STAGES-1:0]]);
        default: rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clkk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_ff @(posedge clkk) begin
    if (reset) begin
      in_cnt                 <= '0;
      out_cnt                <= '0;
      lat_cnt                <= '0;
      error                  <= 1'b0;
      core_start             <= 1'b0;
      cpu_if_access_complete <= 1'b0;
      cpu_if_read_data       <= '0;
    end else begin
      core_start             <= launch;
      cpu_if_access_complete <= cpu_if_read | cpu_if_write;
      cpu_if_read_data       <= rd_value;
      // A fresh error outranks a clear issued in the same cycle.
      error                  <= err_set | (error & ~err_clr);
      if (in_accept) in_cnt <= in_cnt + CW'(1);
      if (launch)
        lat_cnt <= '0;
      else if ((state == ST_RUN) && !capture)
        lat_cnt <= lat_cnt + LW'(1);
      if (out_accept) begin
        if (last_out) begin
          in_cnt  <= '0;
          out_cnt <= '0;
        end else begin
          out_cnt <= out_cnt + CW'(1);
        end
      end
    end
  end

  // Sample buffers carry no reset; counters and state decide what is valid.
  always_ff @(posedge clkk) begin
    if (in_accept && !reset) x_mem[in_cnt[NO_STAGES-1:0]] <= cpu_if_write_data[SW-1:0];
    if (capture && !reset) begin
      for (int i = 0; i < N; i++) y_mem[i] <= core_y_N[i*SW +: SW];
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: randomized CPU traffic against a queue-based frame model,
// with a reversing core whose result is valid only in its latency cycle.
module tb_fft_frame_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int LAT = 10;
  localparam int SW  = DW / 2;
  localparam int N   = 2 ** NS;

  logic          clkk = 1'b0;
  logic          reset, cpu_if_read, cpu_if_write;
  logic [AW-1:0] cpu_if_address;
  logic [DW-1:0] cpu_if_write_data, cpu_if_read_data;
  logic          cpu_if_access_complete, core_start, error, irq;
  logic [N*SW-1:0] core_x_N, core_y_N, rev_x, exp_x;

  int core_age = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain counters plus queues of samples and expected reads.
  int            m_state, m_in, m_out;
  bit            m_err;
  logic [SW-1:0] frame[$];
  logic [DW-1:0] exp_q[$];

  fft_frame_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_STAGES(NS), .CORE_LATENCY(LAT)
  ) dut (
    .clkk(clkk), .reset(reset),
    .cpu_if_read(cpu_if_read), .cpu_if_write(cpu_if_write),
    .cpu_if_address(cpu_if_address), .cpu_if_write_data(cpu_if_write_data),
    .cpu_if_read_data(cpu_if_read_data), .cpu_if_access_complete(cpu_if_access_complete),
    .core_x_N(core_x_N), .core_y_N(core_y_N), .core_start(core_start),
    .error(error), .irq(irq)
  );

  // Clock / reset and the core model
  always #5 clkk = ~clkk;

  always_comb begin
    rev_x = '0;
    for (int i = 0; i < N; i++) rev_x[i*SW +: SW] = core_x_N[(N-1-i)*SW +: SW];
  end
  assign core_y_N = (core_age == LAT) ? rev_x : ~rev_x;

  always @(posedge clkk) begin
    if (reset)                            core_age <= 0;
    else if (core_start)                  core_age <= 1;
    else if (core_age != 0 && core_age < 1000) core_age <= core_age + 1;
  end

  // Reference model
  function automatic void model_reset();
    m_state = 0; m_in = 0; m_out = 0; m_err = 1'b0;
    frame.delete(); exp_q.delete();
  endfunction

  function automatic logic [DW-1:0] status_exp();
    return {m_err, 5'd0, 2'(m_state), 12'(m_out), 12'(m_in)};
  endfunction

  function automatic void model_launch();
    exp_x = '0;
    for (int i = 0; i < N; i++) begin
      exp_x[i*SW +: SW] = frame[i];
      exp_q.push_back(DW'(frame[N-1-i]));
    end
    frame.delete();
    m_state = 1;
  endfunction

  function automatic logic [DW-1:0] model_access(input bit rd, input bit wr, input int off,
                                                 input logic [DW-1:0] wd);
    logic [DW-1:0] r;
    r = '0;
    if (rd && wr) begin
      m_err = 1'b1;
      return r;
    end
    if (wr && off == 0) begin
      if (wd[1]) m_err = 1'b0;
`ifndef FFT_FRAME_AUTO_START_EN
      if (wd[0] && m_state == 0 && m_in == N) model_launch();
`endif
    end
    if (wr && off == 8) begin
      if (m_state == 0 && m_in < N) begin
        frame.push_back(wd[SW-1:0]);
        m_in++;
`ifdef FFT_FRAME_AUTO_START_EN
        if (m_in == N) model_launch();
`endif
      end else begin
        m_err = 1'b1;
      end
    end
    if (rd && off == 4) r = status_exp();
    if (rd && off == 12) begin
      if (m_state == 2 && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        m_out++;
        if (m_out == N) begin m_state = 0; m_in = 0; m_out = 0; end
      end else begin
        m_err = 1'b1;
      end
    end
    return r;
  endfunction

  // Driver: one strobe cycle, outputs sampled 1 time unit after the acknowledging edge
  task automatic xact(input bit rd, input bit wr, input int off, input logic [DW-1:0] wd,
                      output logic [DW-1:0] got, output logic [DW-1:0] exp, output logic ack);
    exp = model_access(rd, wr, off, wd);
    cpu_if_read       = rd;
    cpu_if_write      = wr;
    cpu_if_address    = ($urandom & 32'hFFFF_FFF0) | 32'(off) | 32'($urandom_range(0, 3));
    cpu_if_write_data = wd;
    @(posedge clkk); #1;
    cpu_if_read  = 1'b0;
    cpu_if_write = 1'b0;
    got = cpu_if_read_data;
    ack = cpu_if_access_complete;
  endtask

  task automatic wait_irq(input int exact);
    int cyc, pulses, unstable;
    cyc = 0; pulses = 0; unstable = 0;
    while (irq !== 1'b1 && cyc < 200) begin
      @(posedge clkk); #1;
      cyc++;
      if (core_start === 1'b1) pulses++;
      if (core_x_N !== exp_x) unstable++;
    end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_timeout: irq=%b after %0d cycles, required 1", irq, cyc); end
    if (exact >= 0) begin
      n_cmp++;
      if (cyc != exact) begin n_bad++; $display("FAIL drain_latency: %0d cycles, required %0d", cyc, exact); end
    end
    n_cmp++;
    if (pulses != 0 || unstable != 0) begin
      n_bad++; $display("FAIL run_phase: extra core_start=%0d unstable_x=%0d, required 0/0", pulses, unstable);
    end
    m_state = 2;
  endtask

  task automatic drain_frame();
    logic [DW-1:0] got, exp;
    logic ack;
    for (int i = 0; i < N; i++) begin
      xact(1'b1, 1'b0, 12, $urandom, got, exp, ack);
      n_cmp++;
      if (got !== exp || ack !== 1'b1) begin
        n_bad++; $display("FAIL drain_out[%0d]: got %h ack %b, required %h ack 1", i, got, ack, exp);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_after_drain: %b, required 0", irq); end
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL status_after_drain: got %h, required %h", got, exp); end
  endtask

  // Tests
  task automatic test_reset();
    logic [DW-1:0] got, exp;
    logic ack;
    reset = 1'b1; cpu_if_read = 1'b0; cpu_if_write = 1'b0;
    cpu_if_address = '0; cpu_if_write_data = '0;
    repeat (3) @(posedge clkk);
    #1 reset = 1'b0;
    model_reset();
    n_cmp++;
    if ({irq, error, core_start, cpu_if_access_complete} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: irq/err/start/ack=%b, required 0000",
                        {irq, error, core_start, cpu_if_access_complete});
    end
    n_cmp++;
    if (cpu_if_read_data !== '0) begin n_bad++; $display("FAIL reset_rdata: %h, required 0", cpu_if_read_data); end
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL reset_status_ack: %b, required 1", ack); end
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_status: got %h, required %h", got, exp); end
    @(posedge clkk); #1;
    n_cmp++;
    if (cpu_if_access_complete !== 1'b0) begin n_bad++; $display("FAIL ack_width: %b, required 0", cpu_if_access_complete); end
  endtask

  task automatic test_frame(input bit fixed, input bit poke);
    logic [DW-1:0] got, exp, wd;
    logic ack;
    int bad_ack;
    bad_ack = 0;
    for (int i = 0; i < N; i++) begin
      wd = fixed ? DW'(i) : DW'($urandom);
      xact(1'b0, 1'b1, 8, wd, got, exp, ack);
      if (ack !== 1'b1 || got !== '0) bad_ack++;
    end
    n_cmp++;
    if (bad_ack != 0) begin n_bad++; $display("FAIL load_ack: %0d bad write acks, required 0", bad_ack); end
`ifndef FFT_FRAME_AUTO_START_EN
    n_cmp++;
    if (core_start !== 1'b0) begin n_bad++; $display("FAIL early_start: %b, required 0", core_start); end
    xact(1'b0, 1'b1, 0, 32'h1, got, exp, ack);
`endif
    n_cmp++;
    if (core_start !== 1'b1) begin n_bad++; $display("FAIL core_start: %b, required 1", core_start); end
    n_cmp++;
    if (core_x_N !== exp_x) begin n_bad++; $display("FAIL core_x: got %h, required %h", core_x_N, exp_x); end
    if (poke) begin
      xact(1'b1, 1'b0, 4, '0, got, exp, ack);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL status_in_run: got %h, required %h", got, exp); end
      xact(1'b0, 1'b1, 0, 32'h1, got, exp, ack);
      n_cmp++;
      if (error !== m_err) begin n_bad++; $display("FAIL start_in_run_err: %b, required %b", error, m_err); end
      wait_irq(-1);
    end else begin
      wait_irq(LAT + 1);
    end
    drain_frame();
  endtask

  task automatic test_errors();
    logic [DW-1:0] got, exp;
    logic ack;
    xact(1'b1, 1'b0, 12, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp || error !== m_err) begin
      n_bad++; $display("FAIL out_in_load: got %h err %b, required %h err %b", got, error, exp, m_err);
    end
    xact(1'b0, 1'b1, 0, 32'h2, got, exp, ack);
    n_cmp++;
    if (error !== m_err) begin n_bad++; $display("FAIL clear_err: %b, required %b", error, m_err); end
    xact(1'b1, 1'b1, 8, $urandom, got, exp, ack);
    n_cmp++;
    if (ack !== 1'b1 || got !== exp || error !== m_err) begin
      n_bad++; $display("FAIL rd_wr_conflict: ack %b got %h err %b, required 1 %h %b", ack, got, error, exp, m_err);
    end
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL status_conflict: got %h, required %h", got, exp); end
    xact(1'b0, 1'b1, 0, 32'h2, got, exp, ack);
    xact(1'b1, 1'b0, 0, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL read_ctrl: got %h, required %h", got, exp); end
    xact(1'b1, 1'b0, 8, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL read_data_in: got %h, required %h", got, exp); end
    xact(1'b0, 1'b1, 0, 32'h1, got, exp, ack);
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL early_start_ignored: got %h, required %h", got, exp); end
    for (int i = 0; i < N + 1; i++) xact(1'b0, 1'b1, 8, $urandom, got, exp, ack);
    n_cmp++;
    if (error !== m_err) begin n_bad++; $display("FAIL overflow_err: %b, required %b", error, m_err); end
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL status_overflow: got %h, required %h", got, exp); end
    xact(1'b0, 1'b1, 0, 32'h2, got, exp, ack);
    n_cmp++;
    if (error !== m_err) begin n_bad++; $display("FAIL clear_after_overflow: %b, required %b", error, m_err); end
`ifndef FFT_FRAME_AUTO_START_EN
    xact(1'b0, 1'b1, 0, 32'h1, got, exp, ack);
`endif
    wait_irq(-1);
    drain_frame();
  endtask

  task automatic test_reset_in_run();
    logic [DW-1:0] got, exp;
    logic ack;
    int hi;
    for (int i = 0; i < N; i++) xact(1'b0, 1'b1, 8, $urandom, got, exp, ack);
`ifndef FFT_FRAME_AUTO_START_EN
    xact(1'b0, 1'b1, 0, 32'h1, got, exp, ack);
`endif
    repeat (5) @(posedge clkk);
    #1 reset = 1'b1;
    @(posedge clkk);
    #1 reset = 1'b0;
    model_reset();
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL status_after_run_reset: got %h, required %h", got, exp); end
    hi = 0;
    repeat (3 * LAT) begin
      @(posedge clkk); #1;
      if (irq !== 1'b0) hi++;
    end
    n_cmp++;
    if (hi != 0) begin n_bad++; $display("FAIL irq_after_run_reset: high %0d cycles, required 0", hi); end
    xact(1'b1, 1'b0, 4, '0, got, exp, ack);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL status_settled: got %h, required %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) test_frame(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_frame(1'b1, 1'b0);
    test_frame(1'b0, 1'b1);
    test_errors();
    test_reset_in_run();
    test_frame(1'b0, 1'b0);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, CPU address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, CPU data width; sample width SW = DATA_WIDTH/2.
REQ-003 SHALL have parameter NO_STAGES, default 4, FFT stages; N = 2**NO_STAGES points.
REQ-004 SHALL have parameter CORE_LATENCY, default 10, core input-to-output cycles (>=1).
REQ-005 SHALL have port clkk  in  1  clock for all logic.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports cpu_if_read and cpu_if_write  in  1 each  single-cycle access strobes.
REQ-008 SHALL have port cpu_if_address  in  ADDR_WIDTH  byte address; only bits [3:2] decoded.
REQ-009 SHALL have port cpu_if_write_data  in  DATA_WIDTH  write data.
REQ-010 SHALL have port cpu_if_read_data  out  DATA_WIDTH  read data, valid with access_complete.
REQ-011 SHALL have port cpu_if_access_complete  out  1  one-cycle acknowledge.
REQ-012 SHALL have port core_x_N  out  N*SW  frame to core, sample i at bits [i*SW +: SW].
REQ-013 SHALL have port core_y_N  in  N*SW  core result, same packing.
REQ-014 SHALL have port core_start  out  1  one-cycle pulse, frame launched.
REQ-015 SHALL have port error  out  1  sticky error flag.
REQ-016 SHALL have port irq  out  1  level, high while state is DRAIN.

Function
REQ-017 SHALL decode registers: 0x0 CTRL (W: bit0 start, bit1 clear error), 0x4 STATUS (R), 0x8 DATA_IN (W), 0xC DATA_OUT (R).
REQ-018 STATUS SHALL read {error at bit31, state[1:0] at [25:24], out_cnt at [23:12], in_cnt at [11:0]}, zeros elsewhere.
REQ-019 Every accepted strobe SHALL assert access_complete exactly one cycle later with read_data registered on that cycle; writes return read_data 0.
REQ-020 Simultaneous read and write SHALL perform neither, set error, and still acknowledge.
REQ-021 State machine SHALL have states LOAD(0), RUN(1), DRAIN(2).
REQ-022 In LOAD, DATA_IN write SHALL store write_data[SW-1:0] at in_cnt and increment in_cnt (0..N).
REQ-023 DATA_IN write with in_cnt==N or outside LOAD SHALL be dropped and set error.
REQ-024 CTRL start in LOAD with in_cnt==N SHALL enter RUN, pulse core_start in the same cycle core_x_N holds the frame; start otherwise SHALL be ignored, no error.
REQ-025 RUN SHALL count CORE_LATENCY cycles after core_start, then capture core_y_N into the output buffer and enter DRAIN next cycle.
REQ-026 core_x_N SHALL stay stable from core_start until capture.
REQ-027 In DRAIN, DATA_OUT read SHALL return {SW zeros, y[out_cnt]} and increment out_cnt; the Nth read SHALL return to LOAD with in_cnt=out_cnt=0.
REQ-028 DATA_OUT read outside DRAIN SHALL return 0 and set error.
REQ-029 Reads of STATUS SHALL have no side effects; reads of CTRL and DATA_IN SHALL return 0.
REQ-030 CTRL clear-error SHALL clear error; a new error in the same cycle SHALL win.
REQ-031 CPU accesses during RUN to STATUS/CTRL SHALL be serviced normally.

Reset
REQ-032 Reset SHALL force state LOAD, in_cnt=out_cnt=0, error=0, irq=0, core_start=0, access_complete=0, read_data=0; sample buffers need not be reset.
REQ-033 Reset in RUN or DRAIN SHALL abandon the frame; capture SHALL not occur afterwards.

Configuration
REQ-034 Macro FFT_FRAME_AUTO_START_EN defined: the Nth accepted DATA_IN write SHALL enter RUN and pulse core_start the next cycle without CTRL start; CTRL start bit ignored.
REQ-035 Macro undefined: RUN SHALL be entered only per REQ-024.

Verification
REQ-036 Reset, read STATUS -> read_data 0x00000000, access_complete one cycle after strobe.
REQ-037 Write samples 0..15 to 0x8, start to 0x0 -> core_start one pulse, DRAIN entered 11 cycles later, irq=1.
REQ-038 Core model y[i]=x[15-i]; read 0xC 16 times -> 15,14..0, then STATUS state=0, irq=0.
REQ-039 17th DATA_IN write -> dropped, error=1; write 0x2 to 0x0 -> error=0.
REQ-040 Read 0xC in LOAD -> 0, error=1; simultaneous read/write -> error=1, ack asserted.
REQ-041 Reset 5 cycles into RUN -> state LOAD, no capture, irq stays 0; with FFT_FRAME_AUTO_START_EN, 16th write -> core_start next cycle.
